// File: rtl/serial_arb_pkg.sv
// Shared types, default sizes and the round-robin pick used by the serial lane arbiter.
package serial_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_N_PORTS = 4;
    localparam int MAX_PORTS   = 32;
    localparam int MAX_ID_W    = 5;

    // First set request at or after ptr, searching upward and wrapping at n.
    function automatic int unsigned rr_pick(input logic [MAX_PORTS-1:0] req,
                                            input int unsigned ptr,
                                            input int unsigned n);
        int unsigned idx;
        logic        found;
        found   = 1'b0;
        rr_pick = ptr;
        for (int unsigned i = 0; i < MAX_PORTS; i++) begin
            idx = ptr + i;
            if (idx >= n) idx = idx - n;
            if (!found && (i < n) && req[idx[MAX_ID_W-1:0]]) begin
                found   = 1'b1;
                rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/serial_lane_arbiter_if.sv
// Bundle between the serial requesters / word consumer (master) and the arbiter (slave).
interface serial_lane_arbiter_if
    import serial_arb_pkg::*;
#(
    parameter int width   = DEF_WIDTH,
    parameter int n_ports = DEF_N_PORTS
);
    localparam int id_w = $clog2(n_ports);

    // Handshake: a port raises req[p] and holds it until grant[p] is seen; while granted it
    // sends one bit per cycle with serial_valid[p] high (gaps allowed). Dropping req[p] before
    // the last bit aborts the word. parallel_valid is a one-cycle pulse with no backpressure.
    logic [n_ports-1:0] req;
    logic [n_ports-1:0] serial_valid;
    logic [n_ports-1:0] serial_data;
    logic [n_ports-1:0] grant;
    logic               parallel_valid;
    logic [width-1:0]   parallel_data;
    logic [id_w-1:0]    parallel_id;

    modport master (
        output req, serial_valid, serial_data,
        input  grant, parallel_valid, parallel_data, parallel_id
    );

    modport slave (
        input  req, serial_valid, serial_data,
        output grant, parallel_valid, parallel_data, parallel_id
    );

endinterface

// File: rtl/serial_to_parallel.sv
// LSB-first deserializer: collects width accepted bits and pulses the assembled word.
module serial_to_parallel #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_valid,
    input  logic             serial_data,
    output logic             parallel_valid,
    output logic [width-1:0] parallel_data
);
    localparam int cnt_w = $clog2(width);

    logic [width-2:0] shift_q;
    logic [cnt_w-1:0] cnt_q;
    logic [width-1:0] shifted;

    // New bits enter at the top so the first bit ends up in bit 0 after width shifts.
    assign shifted = {serial_data, shift_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q        <= '0;
            cnt_q          <= '0;
            parallel_valid <= 1'b0;
            parallel_data  <= '0;
        end else begin
            parallel_valid <= 1'b0;
            if (serial_valid) begin
                shift_q <= shifted[width-1:1];
                if (cnt_q == cnt_w'(width - 1)) begin
                    cnt_q          <= '0;
                    parallel_valid <= 1'b1;
                    parallel_data  <= shifted;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/serial_lane_arbiter.sv
// Round-robin arbiter lending one shared deserializer to a single serial requester per word;
// each delivered word is tagged with the index of the port that sent it.
module serial_lane_arbiter
    import serial_arb_pkg::*;
#(
    parameter int width   = DEF_WIDTH,
    parameter int n_ports = DEF_N_PORTS,
    localparam int id_w   = $clog2(n_ports),
    localparam int cnt_w  = $clog2(width)
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_lane_arbiter_if.slave bus,
    output arb_state_t           dbg_state,
    output logic [id_w-1:0]      dbg_ptr
);
    arb_state_t         state, state_nxt;
    logic [n_ports-1:0] grant_q, grant_nxt;
    logic [id_w-1:0]    id_q, id_nxt;
    logic [id_w-1:0]    ptr, ptr_nxt;
    logic [cnt_w-1:0]   bit_cnt, bit_cnt_nxt;
    logic [id_w-1:0]    pick;
    logic [id_w-1:0]    id_inc;
    logic               accept, last_bit, flush;
    logic               s2p_data, s2p_rst;

    assign pick   = id_w'(rr_pick(MAX_PORTS'(bus.req), 32'(ptr), unsigned'(n_ports)));
    assign id_inc = (id_q == id_w'(n_ports - 1)) ? '0 : id_q + 1'b1;

    // grant_q is zero outside ARB_BUSY, so it doubles as the mux enable.
    assign accept   = grant_q[id_q] & bus.serial_valid[id_q];
    assign s2p_data = grant_q[id_q] & bus.serial_data[id_q];
    assign last_bit = accept && (bit_cnt == cnt_w'(width - 1));
    // A final bit arriving together with a dropped request still completes the word.
    assign flush    = (state == ARB_BUSY) && !bus.req[id_q] && !last_bit;
    assign s2p_rst  = rst || flush;

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant_q;
        id_nxt      = id_q;
        ptr_nxt     = ptr;
        bit_cnt_nxt = bit_cnt;
        case (state)
            ARB_IDLE: begin
                grant_nxt = '0;
                if (|bus.req) begin
                    state_nxt       = ARB_BUSY;
                    grant_nxt[pick] = 1'b1;
                    id_nxt          = pick;
                    bit_cnt_nxt     = '0;
                end
            end
            ARB_BUSY: begin
                if (last_bit || flush) begin
                    state_nxt = ARB_IDLE;
                    grant_nxt = '0;
                    ptr_nxt   = id_inc;
                end else if (accept) begin
                    bit_cnt_nxt = bit_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ARB_IDLE;
            grant_q <= '0;
            id_q    <= '0;
            ptr     <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            grant_q <= grant_nxt;
            id_q    <= id_nxt;
            ptr     <= ptr_nxt;
            bit_cnt <= bit_cnt_nxt;
        end
    end

    serial_to_parallel #(
        .width(width)
    ) u_s2p (
        .clk           (clk),
        .rst           (s2p_rst),
        .serial_valid  (accept),
        .serial_data   (s2p_data),
        .parallel_valid(bus.parallel_valid),
        .parallel_data (bus.parallel_data)
    );

    assign bus.grant       = grant_q;
    assign bus.parallel_id = id_q;
    assign dbg_state       = state;
    assign dbg_ptr         = ptr;

endmodule

// File: tb/tb_serial_lane_arbiter.sv
// Bench for serial_lane_arbiter: reactive serial sources, a port-ownership reference model
// and a scoreboard of expected words checked by an independent output monitor.
module tb_serial_lane_arbiter;
    import serial_arb_pkg::*;

    localparam int W   = 8;
    localparam int N   = 4;
    localparam int IDW = $clog2(N);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_lane_arbiter_if #(.width(W), .n_ports(N)) bus ();
    arb_state_t     dbg_state;
    logic [IDW-1:0] dbg_ptr;

    serial_lane_arbiter #(.width(W), .n_ports(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .dbg_state(dbg_state),
        .dbg_ptr  (dbg_ptr)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [W-1:0] exp_q[$];
    int           exp_id_q[$];
    int           exp_cyc_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Output monitor: every word pulse must match the oldest expected word.
    always @(negedge clk) begin
        logic [W-1:0] ed;
        int eid;
        int ec;
        if (!rst && bus.parallel_valid !== 1'b0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got data 0x%0h id %0d at cycle %0d, required no word",
                         bus.parallel_data, bus.parallel_id, cyc);
            end else begin
                ed  = exp_q.pop_front();
                eid = exp_id_q.pop_front();
                ec  = exp_cyc_q.pop_front();
                check("word_data", 64'(bus.parallel_data), 64'(ed));
                check("word_id", 64'(bus.parallel_id), 64'(eid));
                check("word_cycle", 64'(cyc), 64'(ec));
            end
        end
    end

    // Source state, one entry per port.
    int           pend[N];
    logic [W-1:0] word[N];
    int           bidx[N];
    int           gap[N];
    int           gap_cnt[N];
    int           abort_at[N];
    bit           drop_last[N];

    // Reference model: who owns the lane and where the round-robin search starts.
    int           m_owner;
    int           m_ptr;
    logic [N-1:0] req_prev;
    bit           last_prev;
    logic [N-1:0] prev_g;
    int           grant_seq[$];

    function automatic int model_pick(input logic [N-1:0] r, input int p);
        for (int j = 0; j < N; j++) begin
            if (r[(p + j) % N]) return (p + j) % N;
        end
        return -1;
    endfunction

    task automatic clear_sources();
        for (int p = 0; p < N; p++) begin
            pend[p]      = 0;
            word[p]      = W'($urandom);
            bidx[p]      = 0;
            gap[p]       = 0;
            gap_cnt[p]   = 0;
            abort_at[p]  = -1;
            drop_last[p] = 1'b0;
        end
    endtask

    task automatic do_reset(input bit check_outputs);
        rst              = 1'b1;
        bus.req          = '0;
        bus.serial_valid = '0;
        bus.serial_data  = '0;
        @(posedge clk);
        #1;
        if (check_outputs) begin
            check("rst_grant", 64'(bus.grant), 64'd0);
            check("rst_pvalid", 64'(bus.parallel_valid), 64'd0);
            check("rst_pdata", 64'(bus.parallel_data), 64'd0);
            check("rst_pid", 64'(bus.parallel_id), 64'd0);
            check("rst_ptr", 64'(dbg_ptr), 64'd0);
            check("rst_state", 64'(dbg_state), 64'(ARB_IDLE));
        end
        rst       = 1'b0;
        m_owner   = -1;
        m_ptr     = 0;
        req_prev  = '0;
        last_prev = 1'b0;
        prev_g    = '0;
        clear_sources();
        grant_seq.delete();
    endtask

    // One clock: check the grant against the model, then let every source drive its lines.
    task automatic step();
        logic [N-1:0] exp_g, g, req_v, sv_v, sd_v;
        bit last_now;
        last_now = 1'b0;
        exp_g    = '0;
        @(posedge clk);
        #1;
        g = bus.grant;
        if (m_owner < 0) begin
            if (req_prev != '0) begin
                m_owner        = model_pick(req_prev, m_ptr);
                exp_g[m_owner] = 1'b1;
            end
        end else if (last_prev || !req_prev[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end else begin
            exp_g[m_owner] = 1'b1;
        end
        check("grant", 64'(g), 64'(exp_g));
        if (g != '0 && prev_g == '0) begin
            for (int p = 0; p < N; p++) if (g[p]) grant_seq.push_back(p);
        end
        prev_g = g;

        for (int p = 0; p < N; p++) begin
            req_v[p] = (pend[p] > 0);
            sv_v[p]  = 1'($urandom_range(0, 1));
            sd_v[p]  = 1'($urandom_range(0, 1));
            if (g[p] && pend[p] > 0) begin
                if (abort_at[p] == bidx[p]) begin
                    req_v[p]    = 1'b0;
                    sv_v[p]     = (bidx[p] < W - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                    abort_at[p] = -1;
                    bidx[p]     = 0;
                    gap_cnt[p]  = 0;
                    word[p]     = W'($urandom);
                end else if (gap_cnt[p] > 0) begin
                    sv_v[p] = 1'b0;
                    gap_cnt[p]--;
                end else begin
                    sv_v[p]    = 1'b1;
                    sd_v[p]    = word[p][bidx[p]];
                    bidx[p]++;
                    gap_cnt[p] = gap[p];
                    if (bidx[p] == W) begin
                        exp_q.push_back(word[p]);
                        exp_id_q.push_back(p);
                        exp_cyc_q.push_back(cyc + 1);
                        last_now   = 1'b1;
                        pend[p]--;
                        bidx[p]    = 0;
                        gap_cnt[p] = 0;
                        word[p]    = W'($urandom);
                        if (drop_last[p]) req_v[p] = 1'b0;
                    end
                end
            end
        end
        bus.req          = req_v;
        bus.serial_valid = sv_v;
        bus.serial_data  = sd_v;
        req_prev         = req_v;
        last_prev        = last_now;
    endtask

    task automatic run_until_idle(input string name, input int budget);
        int n;
        int quiet;
        bit busy;
        n     = 0;
        quiet = 0;
        while (n < budget && quiet < 3) begin
            step();
            n++;
            busy = (m_owner >= 0) || (exp_q.size() != 0);
            for (int p = 0; p < N; p++) if (pend[p] > 0) busy = 1'b1;
            quiet = busy ? 0 : quiet + 1;
        end
        check({name, "_drained"}, 64'(quiet >= 3), 64'd1);
    endtask

    task automatic run_until_bits(input int p, input int k, input int budget);
        int n;
        n = 0;
        while (n < budget && bidx[p] != k) begin
            step();
            n++;
        end
        check("bits_reached", 64'(bidx[p]), 64'(k));
    endtask

    initial begin
        int rr_exp[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int ab_exp[3] = '{0, 1, 0};

        clear_sources();
        do_reset(1'b1);

        // Single word 1,0,1,1,0,0,1,0 from port 2.
        pend[2] = 1;
        word[2] = 8'h4D;
        run_until_idle("single", 40);
        check("single_grants", 64'(grant_seq.size()), 64'd1);

        // Everyone requesting continuously.
        do_reset(1'b0);
        for (int p = 0; p < N; p++) pend[p] = 2;
        run_until_idle("round_robin", 150);
        check("rr_count", 64'(grant_seq.size()), 64'd8);
        for (int i = 0; i < grant_seq.size() && i < 8; i++)
            check("rr_order", 64'(grant_seq[i]), 64'(rr_exp[i]));

        // Gapped valid on port 1 while the other lanes toggle randomly.
        do_reset(1'b0);
        pend[1] = 1;
        word[1] = 8'hA5;
        gap[1]  = 3;
        run_until_idle("gapped", 80);

        // Abort after 4 bits with port 1 waiting.
        do_reset(1'b0);
        pend[0]     = 1;
        abort_at[0] = 4;
        pend[1]     = 1;
        run_until_idle("abort", 100);
        check("abort_count", 64'(grant_seq.size()), 64'd3);
        for (int i = 0; i < grant_seq.size() && i < 3; i++)
            check("abort_order", 64'(grant_seq[i]), 64'(ab_exp[i]));

        // Request falls in the same cycle as the final bit.
        do_reset(1'b0);
        pend[2]      = 1;
        drop_last[2] = 1'b1;
        run_until_idle("drop_last", 40);

        // Reset in the middle of a port-1 word, with the pointer away from zero.
        do_reset(1'b0);
        pend[2] = 1;
        run_until_idle("pre_reset", 40);
        pend[1] = 1;
        run_until_bits(1, 5, 40);
        do_reset(1'b1);
        pend[0] = 1;
        run_until_idle("post_reset", 40);

        // Random mix of requests, gaps, aborts and late drops.
        do_reset(1'b0);
        for (int r = 0; r < 10; r++) begin
            for (int p = 0; p < N; p++) begin
                pend[p]      = $urandom_range(0, 2);
                gap[p]       = $urandom_range(0, 2);
                abort_at[p]  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, W - 1) : -1;
                drop_last[p] = 1'($urandom_range(0, 1));
            end
            run_until_idle("random", 400);
        end

        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_lane_arbiter.md
# serial_lane_arbiter

Round-robin scheduler that shares one serial-to-parallel deserializer between `n_ports` serial requesters. It grants the lane to one requester for exactly one `width`-bit word and forwards only that requester's bits. It then emits the assembled word tagged with the source port id and rotates priority. It sits between multiple bit-serial sources (sensor lanes, debug taps) and a single word-wide consumer.

## Interface
- `width`, 8: bits per word; must be ≥ 2.
- `n_ports`, 4: number of requesters; must be ≥ 2.
- `id_w`, `$clog2(n_ports)`: width of the port id (derived; not overridden).
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  n_ports  per-port request to send one word; held until granted.
- `serial_valid`  in  n_ports  per-port bit strobe.
- `serial_data`  in  n_ports  per-port bit value.
- `grant`  out  n_ports  one-hot (or zero) registered grant.
- `parallel_valid`  out  1  one-cycle pulse: a word is complete.
- `parallel_data`  out  width  assembled word; meaningful only while `parallel_valid` is high.
- `parallel_id`  out  id_w  index of the port that sent the word currently on `parallel_data`.

## Operation
- The FSM has two states.
  - ARB_IDLE: `grant` = 0. If any `req` bit is high, pick the first set bit at or after `ptr`, searching upward with wrap. Register the one-hot `grant`, capture its index into `parallel_id`, load `bit_cnt` = 0, and go to ARB_BUSY.
  - ARB_BUSY: only `serial_valid[g]` and `serial_data[g]` of the granted port `g` reach the deserializer. All other ports' bits are ignored and dropped.
- Bit accounting: each cycle with `serial_valid[g]` = 1 accepts one bit and increments `bit_cnt`. Gaps with valid low are allowed and of any length.
- Word completion: when the accepted bit is bit `width-1`, the next state is ARB_IDLE, `grant` clears, and `ptr` = (g+1) mod `n_ports`.
- Bit order: LSB first. The first accepted bit lands in `parallel_data[0]`.
- Abort: in ARB_BUSY, if `req[g]` = 0 in a cycle that does not also accept the final bit:
  - the partial word is discarded;
  - a flush is driven into the deserializer's synchronous reset (`rst || flush`);
  - the FSM returns to ARB_IDLE and `ptr` = (g+1) mod `n_ports`;
  - no `parallel_valid` is produced.
- Abort vs. completion in the same cycle: the final bit accepted while `req[g]` drops is a normal completion.
- `req` changes of non-granted ports during ARB_BUSY have no effect until the next arbitration.
- Reset values: `grant` = 0, `parallel_valid` = 0, `parallel_data` = 0, `parallel_id` = 0, `ptr` = 0, `bit_cnt` = 0, state ARB_IDLE.
- Reset mid-word behaves like an abort, with no output.
- `bit_cnt` is `$clog2(width)` bits wide. It never wraps, because it reloads at every grant.

## Timing
- Request to grant: `req` sampled high in ARB_IDLE at cycle t gives `grant` high at t+1. Bits are accepted from t+1 onward.
- Completion: final bit accepted at cycle k gives `parallel_valid` high for exactly cycle k+1 and `grant` low at k+1.
- Earliest next grant is k+2. Minimum spacing is `width`+2 cycles per word.
- `parallel_id` is stable from grant until the next grant, so it is valid alongside `parallel_valid`.
- Abort: `req[g]` low at cycle a gives `grant` low at a+1. The deserializer is cleared at edge a+1. Earliest new grant is a+2.
- No combinational path from inputs to outputs.

## Structure
- Shared package `serial_arb_pkg`:
  - `typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t`;
  - default width/port constants;
  - a round-robin `rr_pick(req, ptr)` function returning the index.
- Sub-module: one instance of the existing `serial_to_parallel` deserializer, parameterised with `width`. Its `rst` is tied to `rst || flush`; its serial inputs come from a mux selected by `parallel_id` and gated by `grant`.
- Arbiter FSM, pointer, counter and mux live in the top module.

## Test plan
- Single port: width=8, req[2]=1, port 2 sends bits 1,0,1,1,0,0,1,0 on consecutive cycles. Required: `parallel_data` = 8'h4D with `parallel_id` = 2, pulse one cycle after the last bit, `grant` low the same cycle.
- Round-robin: all four `req` held high continuously. Required: grants issued in order 0,1,2,3,0, each word tagged with the matching id, and no port granted twice before the others.
- Gapped valid and foreign traffic: granted port 1 sends 8'hA5 with 3-cycle valid gaps while port 3 toggles `serial_valid`/`serial_data` randomly. Required: output 8'hA5, id 1, and port 3 bits never appear.
- Abort: port 0 sends 4 bits, then drops `req`. Required: `grant` low next cycle, no `parallel_valid`. Next grant goes to port 1 if requesting; a fresh port-0 word then yields the correct value with no stale bits.
- Simultaneous drop on last bit: `req[g]` falls in the cycle the 8th bit is accepted. Required: word delivered normally.
- Reset mid-word: assert `rst` after 5 bits. Required: all outputs 0 next cycle, `ptr` = 0; the following word from port 0 is correct.
